// File: rtl/regfile_dump.sv
// regfile_dump -- streams the contents of a 32-entry register file to a
// valid/ready consumer. Registers are read two at a time: rs_addr gets the
// even register and rt_addr the odd one. The pair is captured in one cycle
// and then sent as two consecutive words.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   start                 one-cycle request to dump all 32 registers
//                         (ignored while a dump is running)
//   abort                 cancels a running dump (no done pulse);
//                         also wins over start in IDLE
//   rs_addr / rt_addr     register-file read addresses (even / odd of pair k)
//   rs_data / rt_data     register-file read data, combinational from the addresses
//   dout_valid/dout_ready output handshake
//   dout_data/dout_index  register value and register number
//   dout_last             marks the register-31 word
//   busy                  high whenever the FSM is not in IDLE
//   done                  one-cycle pulse after the last word is accepted
module regfile_dump #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [4:0]        rs_addr,
    output logic [4:0]        rt_addr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] dout_data,
    output logic [4:0]        dout_index,
    output logic              dout_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEND0 = 3'd2,
        ST_SEND1 = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t            state_r;
    logic [3:0]        k_r;          // pair counter, stops at 15 (never wraps)
    logic [DATA_W-1:0] b0_r;         // even register of the current pair
    logic [DATA_W-1:0] b1_r;         // odd register of the current pair
    logic [4:0]        rs_addr_r;
    logic [4:0]        rt_addr_r;
    logic              dout_valid_r;
    logic [DATA_W-1:0] dout_data_r;
    logic [4:0]        dout_index_r;
    logic              dout_last_r;
    logic              busy_r;
    logic              done_r;

    // Dump sequencer: state, pair counter, pair buffer and every output register.
    // The outputs are registered. Each value is loaded on the edge that
    // enters the state it belongs to, so it is valid for the whole state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            k_r          <= 4'd0;
            b0_r         <= '0;
            b1_r         <= '0;
            rs_addr_r    <= 5'd0;
            rt_addr_r    <= 5'd0;
            dout_valid_r <= 1'b0;
            dout_data_r  <= '0;
            dout_index_r <= 5'd0;
            dout_last_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else if (abort && (state_r != ST_IDLE)) begin
            // Cancel: drop the current word and return to idle quietly.
            state_r      <= ST_IDLE;
            k_r          <= 4'd0;
            rs_addr_r    <= 5'd0;
            rt_addr_r    <= 5'd0;
            dout_valid_r <= 1'b0;
            dout_last_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_r   <= ST_FETCH;
                        k_r       <= 4'd0;
                        rs_addr_r <= 5'd0;
                        rt_addr_r <= 5'd1;
                        busy_r    <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    // Capture both halves of the pair. The even word goes
                    // straight to the output register as well.
                    b0_r         <= rs_data;
                    b1_r         <= rt_data;
                    dout_data_r  <= rs_data;
                    dout_index_r <= {k_r, 1'b0};
                    dout_last_r  <= 1'b0;
                    dout_valid_r <= 1'b1;
                    state_r      <= ST_SEND0;
                end
                ST_SEND0: begin
                    if (dout_ready) begin
                        dout_data_r  <= b1_r;
                        dout_index_r <= {k_r, 1'b1};
                        dout_last_r  <= (k_r == 4'd15);
                        state_r      <= ST_SEND1;
                    end else begin
                        state_r <= ST_SEND0;
                    end
                end
                ST_SEND1: begin
                    if (dout_ready) begin
                        dout_valid_r <= 1'b0;
                        dout_last_r  <= 1'b0;
                        if (k_r == 4'd15) begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            k_r       <= k_r + 4'd1;
                            rs_addr_r <= {k_r + 4'd1, 1'b0};
                            rt_addr_r <= {k_r + 4'd1, 1'b1};
                            state_r   <= ST_FETCH;
                        end
                    end else begin
                        state_r <= ST_SEND1;
                    end
                end
                ST_DONE: begin
                    // Start is not looked at here. A held start can only
                    // begin a new dump from IDLE on the following edge.
                    done_r    <= 1'b0;
                    busy_r    <= 1'b0;
                    rs_addr_r <= 5'd0;
                    rt_addr_r <= 5'd0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    k_r          <= 4'd0;
                    rs_addr_r    <= 5'd0;
                    rt_addr_r    <= 5'd0;
                    dout_valid_r <= 1'b0;
                    dout_last_r  <= 1'b0;
                    busy_r       <= 1'b0;
                    done_r       <= 1'b0;
                end
            endcase
        end
    end

    assign rs_addr    = rs_addr_r;
    assign rt_addr    = rt_addr_r;
    assign dout_valid = dout_valid_r;
    assign dout_data  = dout_data_r;
    assign dout_index = dout_index_r;
    assign dout_last  = dout_last_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump. The bench models a register file
// with reg[i] = i*8. Each test pushes the words it expects into a queue.
// A separate monitor pops the queue on every accepted word and checks that
// a stalled word does not change. Inputs change 1 time unit after the
// rising edge. The monitor samples on the falling edge.
module tb_regfile_dump;

    localparam int DATA_W = 32;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } word_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [4:0]        rs_addr;
    logic [4:0]        rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              dout_valid;
    logic              dout_ready;
    logic [DATA_W-1:0] dout_data;
    logic [4:0]        dout_index;
    logic              dout_last;
    logic              busy;
    logic              done;

    word_t exp_q[$];
    int    n_cmp  = 0;
    int    n_bad  = 0;
    int    done_cnt = 0;

    // Register file model: reg[i] = i*8
    assign rs_data = {24'd0, rs_addr, 3'd0};
    assign rt_data = {24'd0, rt_addr, 3'd0};

    regfile_dump #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data),
        .dout_index (dout_index),
        .dout_last  (dout_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_words(input int lo, input int hi);
        word_t w;
        for (int i = lo; i <= hi; i++) begin
            w.idx  = 5'(i);
            w.data = 32'(i * 8);
            w.last = (i == 31);
            exp_q.push_back(w);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rs_addr"},    64'(rs_addr),    64'd0);
        check({tag, "_rt_addr"},    64'(rt_addr),    64'd0);
        check({tag, "_dout_valid"}, 64'(dout_valid), 64'd0);
        check({tag, "_dout_last"},  64'(dout_last),  64'd0);
        check({tag, "_busy"},       64'(busy),       64'd0);
        check({tag, "_done"},       64'(done),       64'd0);
        check({tag, "_dout_data"},  64'(dout_data),  64'd0);
        check({tag, "_dout_index"}, 64'(dout_index), 64'd0);
    endtask

    // Monitor / scoreboard
    initial begin
        word_t w;
        word_t held;
        bit    stall_pending;
        stall_pending = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (!rst && !abort && stall_pending) begin
                n_cmp++;
                if (!dout_valid || dout_index !== held.idx || dout_data !== held.data
                    || dout_last !== held.last) begin
                    n_bad++;
                    $display("FAIL stall_stable: got v=%0b idx=%0d data=%0h last=%0b, expected idx=%0d data=%0h last=%0b",
                             dout_valid, dout_index, dout_data, dout_last, held.idx, held.data, held.last);
                end
            end
            if (dout_valid && dout_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL word_unexpected: got idx=%0d data=%0h, expected no word", dout_index, dout_data);
                end else begin
                    w = exp_q.pop_front();
                    if (dout_index !== w.idx || dout_data !== w.data || dout_last !== w.last) begin
                        n_bad++;
                        $display("FAIL word: got idx=%0d data=%0h last=%0b, expected idx=%0d data=%0h last=%0b",
                                 dout_index, dout_data, dout_last, w.idx, w.data, w.last);
                    end
                end
                stall_pending = 1'b0;
            end else if (dout_valid && !rst && !abort) begin
                stall_pending = 1'b1;
                held.idx  = dout_index;
                held.data = dout_data;
                held.last = dout_last;
            end else begin
                stall_pending = 1'b0;
            end
        end
    end

    // Directed stimulus
    initial begin
        int cyc;
        int d0;
        int first_done;
        int second_done;

        rst = 1'b1; start = 1'b0; abort = 1'b0; dout_ready = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Full dump with the consumer always ready
        push_words(0, 31);
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        check("t1_busy_c1", 64'(busy), 64'd1);
        check("t1_rt_addr_c1", 64'(rt_addr), 64'd1);
        while (!done && cyc < 200) begin
            tick();
            cyc++;
            if (cyc == 2) check("t1_valid_c2", 64'({dout_valid, dout_index}), 64'({1'b1, 5'd0}));
            if (cyc == 4) check("t1_fetch1_addr", 64'({rs_addr, rt_addr}), 64'({5'd2, 5'd3}));
        end
        check("t1_done_cycle", 64'(cyc), 64'd49);
        tick();
        check("t1_idle_c50", 64'({busy, done, dout_valid}), 64'd0);
        check("t1_done_count", 64'(done_cnt - d0), 64'd1);
        check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

        // Ready toggling every cycle
        push_words(0, 31);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 400) begin
            tick();
            dout_ready = ~dout_ready;
            cyc++;
        end
        check("t2_done_seen", 64'(done), 64'd1);
        dout_ready = 1'b1;
        tick();
        check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

        // Abort in the SEND1 cycle carrying index 9
        push_words(0, 9);
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (cyc < 15) begin
            tick();
            cyc++;
        end
        check("t3_index9", 64'({dout_valid, dout_index, dout_last}), 64'({1'b1, 5'd9, 1'b0}));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t3_after_abort", 64'({busy, dout_valid}), 64'd0);
        repeat (5) tick();
        check("t3_no_done", 64'(done_cnt - d0), 64'd0);
        check("t3_queue_empty", 64'(exp_q.size()), 64'd0);
        push_words(0, 31);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
        end
        check("t3_redump_done_cycle", 64'(cyc), 64'd49);
        tick();
        check("t3_redump_queue_empty", 64'(exp_q.size()), 64'd0);

        // Start held high for 60 cycles: two back-to-back dumps
        push_words(0, 31);
        push_words(0, 31);
        first_done = 0;
        second_done = 0;
        start = 1'b1;
        tick();
        cyc = 1;
        while (second_done == 0 && cyc < 300) begin
            tick();
            cyc++;
            if (cyc == 60) start = 1'b0;
            if (cyc == 50) check("t4_idle_c50", 64'(busy), 64'd0);
            if (cyc == 51) check("t4_fetch_c51", 64'({busy, rs_addr, rt_addr}), 64'({1'b1, 5'd0, 5'd1}));
            if (done && first_done == 0) first_done = cyc;
            else if (done) second_done = cyc;
        end
        start = 1'b0;
        check("t4_first_done", 64'(first_done), 64'd49);
        check("t4_second_done", 64'(second_done), 64'd99);
        tick();
        check("t4_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset pulsed during FETCH of pair 7
        push_words(0, 13);
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (cyc < 22) begin
            tick();
            cyc++;
        end
        check("t5_fetch7_addr", 64'({busy, dout_valid, rs_addr, rt_addr}), 64'({1'b1, 1'b0, 5'd14, 5'd15}));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("t5_after_rst");
        repeat (5) tick();
        check("t5_no_done", 64'(done_cnt - d0), 64'd0);
        check("t5_still_idle", 64'(busy), 64'd0);
        check("t5_queue_empty", 64'(exp_q.size()), 64'd0);

        // start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_addrs", 64'({rs_addr, rt_addr}), 64'd0);
        start = 1'b0;
        abort = 1'b0;
        tick();
        check("t6_still_idle", 64'({busy, dout_valid}), 64'd0);
        check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 Parameter: DATA_W, 32, register data width.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  one-cycle request to dump all 32 registers.
REQ-005 abort  input  1  cancel a dump in progress.
REQ-006 rs_addr  output  5  register-file read port A address.
REQ-007 rt_addr  output  5  register-file read port B address.
REQ-008 rs_data  input  DATA_W  register-file port A data, combinational from rs_addr.
REQ-009 rt_data  input  DATA_W  register-file port B data, combinational from rt_addr.
REQ-010 dout_valid  output  1  dump word available.
REQ-011 dout_ready  input  1  consumer accepts word this cycle.
REQ-012 dout_data  output  DATA_W  register contents.
REQ-013 dout_index  output  5  register number of dout_data.
REQ-014 dout_last  output  1  high with the index-31 word.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, SEND0, SEND1 and DONE.
REQ-018 IDLE: start=1 and abort=0 SHALL load pair counter k=0 and go to FETCH; otherwise stay in IDLE.
REQ-019 FETCH: rs_addr SHALL be 2k and rt_addr SHALL be 2k+1.
REQ-019a FETCH: rs_data and rt_data SHALL be captured into buffer entries B0 and B1 at the closing edge; next state SEND0.
REQ-020 SEND0: dout_valid=1, dout_data=B0, dout_index=2k; on dout_ready=1 go to SEND1, else hold.
REQ-021 SEND1: dout_valid=1, dout_data=B1, dout_index=2k+1.
REQ-021a SEND1, on dout_ready=1: if k=15 go to DONE, else k=k+1 and go to FETCH; on dout_ready=0 hold.
REQ-022 dout_data, dout_index and dout_last SHALL remain stable while dout_valid=1 and dout_ready=0.
REQ-023 dout_last SHALL be 1 only in SEND1 with k=15.
REQ-024 DONE SHALL assert done=1 for exactly one cycle and then go to IDLE; dout_valid=0 in DONE.
REQ-025 dout_valid SHALL be 0 in IDLE, FETCH and DONE.
REQ-026 rs_addr and rt_addr SHALL be 0 in IDLE and SHALL hold their last FETCH values in SEND0, SEND1 and DONE.
REQ-027 Register 0 SHALL be dumped as read, with no forcing to zero.
REQ-028 start SHALL be ignored in every state except IDLE.
REQ-029 abort=1 in any non-IDLE state SHALL return the FSM to IDLE at the next edge with no done pulse and dout_valid=0 from that cycle on.
REQ-030 abort=1 together with start=1 in IDLE SHALL keep the FSM in IDLE (abort wins).
REQ-031 Timing with start sampled at edge 0 and dout_ready held at 1:
  - FETCH in cycle 1, index 0 valid in cycle 2, index 1 in cycle 3, next FETCH in cycle 4.
  - Index 31 valid in cycle 48, done in cycle 49, IDLE from cycle 50.
REQ-032 The pair counter k SHALL be 4 bits wide and SHALL never wrap within a dump.

Reset
REQ-033 rst=1 SHALL override start and abort, force state IDLE, k=0 and B0=B1=0.
REQ-033a During rst=1: all outputs 0 at the next edge (dout_valid, dout_last, busy, done, rs_addr, rt_addr, dout_data, dout_index).
REQ-034 rst asserted mid-dump SHALL discard the dump; no done pulse SHALL follow.

Verification
REQ-035 Regfile model holds reg[i]=i*8; start pulse, dout_ready=1 -> 32 words in order 0..31, data i*8, dout_last only on 31, done in cycle 49.
REQ-036 dout_ready toggles 1/0 every cycle -> same 32-word sequence; words stay stable while stalled; no word dropped or duplicated.
REQ-037 abort in the SEND1 cycle with index 9 -> IDLE next cycle, busy=0, no done; a new start then dumps from index 0.
REQ-038 start held high for 60 cycles -> exactly one dump, then a second dump starts from the cycle after DONE.
REQ-039 rst pulsed during FETCH of k=7 -> all outputs 0 next cycle, state IDLE, no done.
REQ-040 start=1 and abort=1 together in IDLE -> busy stays 0 and no addresses change.
